// File: rtl/adder_pipe_n_bit_pkg.sv
// Shared definitions for the chunked pipelined adder: mode encoding and
// the parameter sanity check used at elaboration.
package adder_pipe_n_bit_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   function automatic bit chunk_ok(input int unsigned n, input int unsigned k);
      return (k >= 1) && (n >= k) && ((n % k) == 0);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// K-bit combinational ripple chunk; also exposes the carry into its MSB so
// the final stage can form signed overflow.
module adder_chunk #(
   parameter int unsigned K = 4
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         ci,
   output logic [K-1:0] s,
   output logic         co,
   output logic         c_msb_in
);

   logic [K:0] c;

   assign c[0] = ci;

   full_adder u_fa [K-1:0] (
      .a  (a),
      .b  (b),
      .ci (c[K-1:0]),
      .s  (s),
      .co (c[K:1])
   );

   assign co       = c[K];
   assign c_msb_in = c[K-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the cell the chunk ripple is built from.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_pipe_n_bit.sv
// Pipelined N-bit add/subtract: one K-bit chunk per stage, registered chunk
// carries, operand skew ahead of the carry and result de-skew behind it.
module adder_pipe_n_bit #(
   parameter int unsigned N = 16,
   parameter int unsigned K = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] z,
   output logic         cout,
   output logic         ovf
);

   import adder_pipe_n_bit_pkg::*;

   localparam int unsigned STAGES = N / K;

   if (!chunk_ok(N, K)) begin : g_param_check
      $error("adder_pipe_n_bit: N must be a nonzero multiple of K");
   end

   logic         advance;
   logic [N-1:0] y_eff;
   logic         c_first;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign y_eff    = y ^ {N{sub == MODE_SUB}};
   assign c_first  = (sub == MODE_SUB) ? 1'b1 : cin;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      // REM = operand bits still waiting for their carry after this stage
      localparam int unsigned REM = N - (s + 1) * K;

      logic [K-1:0]         a_c;
      logic [K-1:0]         b_c;
      logic [K-1:0]         s_c;
      logic                 ci_c;
      logic                 co_c;
      logic                 v_in;
      logic                 v_r;
      logic                 c_r;
      logic [(s+1)*K-1:0]   res_in;
      logic [(s+1)*K-1:0]   res;

      if (s == 0) begin : g_src
         assign a_c    = x[K-1:0];
         assign b_c    = y_eff[K-1:0];
         assign ci_c   = c_first;
         assign v_in   = in_valid;
         assign res_in = s_c;
      end else begin : g_src
         assign a_c    = g_stage[s-1].g_skew.xs[K-1:0];
         assign b_c    = g_stage[s-1].g_skew.ys[K-1:0];
         assign ci_c   = g_stage[s-1].c_r;
         assign v_in   = g_stage[s-1].v_r;
         assign res_in = {s_c, g_stage[s-1].res};
      end

      if (s == STAGES - 1) begin : g_last
         logic cm_c;
         logic ovf_r;

         adder_chunk #(.K(K)) u_chunk (
            .a        (a_c),
            .b        (b_c),
            .ci       (ci_c),
            .s        (s_c),
            .co       (co_c),
            .c_msb_in (cm_c)
         );

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_r <= 1'b0;
            end else if (advance) begin
               ovf_r <= cm_c ^ co_c;
            end
         end
      end else begin : g_body
         adder_chunk #(.K(K)) u_chunk (
            .a        (a_c),
            .b        (b_c),
            .ci       (ci_c),
            .s        (s_c),
            .co       (co_c),
            .c_msb_in ()
         );
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r <= 1'b0;
            c_r <= 1'b0;
            res <= '0;
         end else if (advance) begin
            v_r <= v_in;
            c_r <= co_c;
            res <= res_in;
         end
      end

      if (s < STAGES - 1) begin : g_skew
         logic [REM-1:0] xs;
         logic [REM-1:0] ys;
         logic [REM-1:0] xs_in;
         logic [REM-1:0] ys_in;

         if (s == 0) begin : g_feed
            assign xs_in = x[N-1:K];
            assign ys_in = y_eff[N-1:K];
         end else begin : g_feed
            assign xs_in = g_stage[s-1].g_skew.xs[REM+K-1:K];
            assign ys_in = g_stage[s-1].g_skew.ys[REM+K-1:K];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               xs <= '0;
               ys <= '0;
            end else if (advance) begin
               xs <= xs_in;
               ys <= ys_in;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_r;
   assign z         = g_stage[STAGES-1].res;
   assign cout      = g_stage[STAGES-1].c_r;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_adder_pipe_n_bit.sv
// Directed self-checking bench for adder_pipe_n_bit at N=16, K=4 (latency 4).
module tb_adder_pipe_n_bit;

   localparam int unsigned N = 16;
   localparam int unsigned K = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] x;
   logic [N-1:0] y;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] z;
   logic         cout;
   logic         ovf;

   int tests = 0;
   int fails = 0;

   adder_pipe_n_bit #(.N(N), .K(K)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one beat, then checks it is absent at +3 and present with the given result at +4
   task automatic beat(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input logic sb,
                       input logic [N-1:0] ez, input logic ec, input logic eo);
      x = a; y = b; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      chk($sformatf("%s_early", tag), out_valid, 1'b0);
      tick();
      chk($sformatf("%s_valid", tag), out_valid, 1'b1);
      chk($sformatf("%s_z", tag), z, ez);
      chk($sformatf("%s_cout", tag), cout, ec);
      chk($sformatf("%s_ovf", tag), ovf, eo);
      tick();
   endtask

   logic [N-1:0] bx [4] = '{16'h00FF, 16'h0F0F, 16'hABCD, 16'h7000};
   logic [N-1:0] by [4] = '{16'h0001, 16'hF0F1, 16'h1234, 16'h1000};
   logic [N-1:0] bz [4] = '{16'h0100, 16'h0000, 16'hBE01, 16'h8000};
   logic         bc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic         bo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int           nsent;
      int           nrecv;
      logic [N-1:0] got [6];
      logic         exp_v;

      rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_z", z, 16'h0000);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      beat("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      beat("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      beat("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      beat("add_full", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      beat("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      beat("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // backpressure: six beats, downstream stalled for cycles 4..8
      nsent = 0;
      nrecv = 0;
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 4 && c <= 8);
         sub = 1'b0; cin = 1'b0;
         if (nsent < 6) begin
            in_valid = 1'b1;
            x = N'(nsent + 1);
            y = N'(nsent + 1);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c >= 4 && c <= 8) begin
            chk($sformatf("stall_in_ready_c%0d", c), in_ready, 1'b0);
            chk($sformatf("stall_z_c%0d", c), z, 16'h0002);
         end
         if (in_valid && in_ready) nsent++;
         if (out_valid && out_ready) begin
            if (nrecv < 6) got[nrecv] = z;
            nrecv++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("bp_count", nrecv, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("bp_result_%0d", i), got[i], N'(2 * (i + 1)));
      end

      // bubbles: beat on even cycles only
      for (int c = 0; c < 16; c++) begin
         out_ready = 1'b1;
         sub = 1'b0; cin = 1'b0;
         if (c < 8 && (c % 2) == 0) begin
            in_valid = 1'b1;
            x = bx[c/2];
            y = by[c/2];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         exp_v = (c >= 4) && (c < 12) && (((c - 4) % 2) == 0);
         chk($sformatf("bub_valid_c%0d", c), out_valid, exp_v);
         if (exp_v) begin
            chk($sformatf("bub_z_c%0d", c), z, bz[(c-4)/2]);
            chk($sformatf("bub_cout_c%0d", c), cout, bc[(c-4)/2]);
            chk($sformatf("bub_ovf_c%0d", c), ovf, bo[(c-4)/2]);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;

      // reset with three beats in flight
      for (int c = 0; c < 4; c++) begin
         out_ready = 1'b1;
         in_valid = (c < 3);
         x = N'(16'h1111 * (c + 1));
         y = 16'h0001;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("pre_rst_out_valid", out_valid, 1'b1);
      chk("pre_rst_z", z, 16'h1112);
      chk("pre_rst_in_ready", in_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_z", z, 16'h0000);
      chk("mid_rst_cout", cout, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("post_rst_idle_c%0d", c), out_valid, 1'b0);
         tick();
      end
      beat("post_rst", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
